wb_bus_arbiter: RTL and testbench

//  Shares one Wishbone classic slave port between two masters: m0 = instruction fetch,
//  m1 = data port of the memory stage. Registered grant FSM, fixed or round-robin

---
 rtl/wb_bus_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_wb_bus_arbiter.sv | 432 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_bus_arbiter.sv
// wb_bus_arbiter
//   Two-master to one-slave Wishbone classic arbiter. m0 is the instruction
//   fetch port, m1 the data port of the memory stage. A registered grant FSM
//   (IDLE, GNT0, GNT1, ERR) picks a master with either fixed priority (m1 wins)
//   or round-robin priority. The grant is held for as long as the granted
//   master keeps cyc asserted. A watchdog terminates accesses that stall too
//   long with a one-cycle err.
//
// Parameters
//   FIXED_PRIO : 1 = m1 wins simultaneous requests, 0 = round-robin
//   TIMEOUT    : stalled-strobe cycles before a forced err, 0 disables
//
// Ports
//   clk_i, rst_i                  clock, synchronous active-high reset
//   m{0,1}_cyc_i/stb_i/we_i       master controls
//   m{0,1}_sel_i/addr_i/dat_i     master byte selects, address, write data
//   m{0,1}_dat_o                  read data (s_dat_i, unqualified)
//   m{0,1}_ack_o/err_o            terminations, granted master only
//   s_cyc_o/stb_o/we_o/sel_o      slave-side controls
//   s_addr_o/dat_o                slave address / write data
//   s_dat_i, s_ack_i, s_err_i     slave read data and terminations
//   grant_o                       one-hot grant {m1,m0}, 00 when idle or in err

module wb_bus_arbiter #(
  parameter int FIXED_PRIO = 1,
  parameter int TIMEOUT    = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  input  logic        m0_we_i,
  input  logic [3:0]  m0_sel_i,
  input  logic [31:0] m0_addr_i,
  input  logic [31:0] m0_dat_i,
  output logic [31:0] m0_dat_o,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  input  logic        m1_we_i,
  input  logic [3:0]  m1_sel_i,
  input  logic [31:0] m1_addr_i,
  input  logic [31:0] m1_dat_i,
  output logic [31:0] m1_dat_o,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic        s_cyc_o,
  output logic        s_stb_o,
  output logic        s_we_o,
  output logic [3:0]  s_sel_o,
  output logic [31:0] s_addr_o,
  output logic [31:0] s_dat_o,
  input  logic [31:0] s_dat_i,
  input  logic        s_ack_i,
  input  logic        s_err_i,
  output logic [1:0]  grant_o
);

  // Counter width; kept at one bit when the watchdog is disabled.
  localparam int WDW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  // Count value at which one more stalled cycle means TIMEOUT stalled cycles.
  localparam logic [WDW-1:0] WD_LAST = (TIMEOUT > 0) ? WDW'(TIMEOUT - 1) : {WDW{1'b0}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2,
    ERR  = 2'd3
  } state_t;

  state_t         state;
  logic           last;     // master granted most recently, 1 = m1
  logic [WDW-1:0] wdog;     // consecutive stalled cycles of the current access
  logic           own;      // index of the master owning the bus in GNTx
  logic           own_cyc;
  logic           stalled;
  logic           wd_hit;

  assign own      = (state == GNT1);
  assign own_cyc  = own ? m1_cyc_i : m0_cyc_i;
  assign stalled  = s_stb_o & ~s_ack_i & ~s_err_i;
  assign wd_hit   = (TIMEOUT > 0) && stalled && (wdog == WD_LAST);

  // Read data is broadcast; masters qualify it with their own ack.
  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;

  // Route the granted master to the slave and the terminations back to it.
  always_comb begin
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    s_we_o   = 1'b0;
    s_sel_o  = 4'h0;
    s_addr_o = 32'h0;
    s_dat_o  = 32'h0;
    m0_ack_o = 1'b0;
    m0_err_o = 1'b0;
    m1_ack_o = 1'b0;
    m1_err_o = 1'b0;
    grant_o  = 2'b00;
    case (state)
      GNT0: begin
        s_cyc_o  = m0_cyc_i;
        s_stb_o  = m0_stb_i;
        s_we_o   = m0_we_i;
        s_sel_o  = m0_sel_i;
        s_addr_o = m0_addr_i;
        s_dat_o  = m0_dat_i;
        m0_ack_o = s_ack_i;
        m0_err_o = s_err_i;
        grant_o  = 2'b01;
      end
      GNT1: begin
        s_cyc_o  = m1_cyc_i;
        s_stb_o  = m1_stb_i;
        s_we_o   = m1_we_i;
        s_sel_o  = m1_sel_i;
        s_addr_o = m1_addr_i;
        s_dat_o  = m1_dat_i;
        m1_ack_o = s_ack_i;
        m1_err_o = s_err_i;
        grant_o  = 2'b10;
      end
      ERR: begin
        // 'last' was loaded with the timed-out master on entry to ERR.
        m0_err_o = ~last;
        m1_err_o = last;
      end
      default: begin
      end
    endcase
  end

  // Grant FSM, last-granted tracking and the stall watchdog.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      last  <= 1'b0;
      wdog  <= {WDW{1'b0}};
    end else begin
      case (state)
        IDLE: begin
          wdog <= {WDW{1'b0}};
          if (m0_cyc_i && m1_cyc_i) begin
            // Round-robin hands the bus to whichever master did not have it last.
            state <= ((FIXED_PRIO != 0) || !last) ? GNT1 : GNT0;
          end else if (m1_cyc_i) begin
            state <= GNT1;
          end else if (m0_cyc_i) begin
            state <= GNT0;
          end else begin
            state <= IDLE;
          end
        end
        GNT0, GNT1: begin
          // A cyc release takes precedence over a watchdog expiry.
          if (!own_cyc) begin
            state <= IDLE;
            last  <= own;
            wdog  <= {WDW{1'b0}};
          end else if (wd_hit) begin
            state <= ERR;
            last  <= own;
            wdog  <= {WDW{1'b0}};
          end else if (stalled && (TIMEOUT > 0)) begin
            wdog  <= wdog + WDW'(1);
          end else begin
            wdog  <= {WDW{1'b0}};
          end
        end
        ERR: begin
          state <= IDLE;
          wdog  <= {WDW{1'b0}};
        end
        default: begin
          state <= IDLE;
          wdog  <= {WDW{1'b0}};
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_bus_arbiter.sv
// Bench for wb_bus_arbiter. Two instances share all inputs: index 0 uses fixed
// priority with TIMEOUT=4, index 1 round-robin with TIMEOUT=6. A reference model
// tracks, per instance, who owns the bus and predicts every output.
module tb_wb_bus_arbiter;

  logic        clk;
  logic        rst;
  logic        m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
  logic [3:0]  m0_sel, m1_sel;
  logic [31:0] m0_addr, m0_dat, m1_addr, m1_dat, s_dat;
  logic        s_ack, s_err;

  logic [31:0] m0_dat_o [2];
  logic [31:0] m1_dat_o [2];
  logic [31:0] s_addr_o [2];
  logic [31:0] s_dat_o  [2];
  logic [3:0]  s_sel_o  [2];
  logic [1:0]  grant_o  [2];
  logic        m0_ack_o [2];
  logic        m1_ack_o [2];
  logic        m0_err_o [2];
  logic        m1_err_o [2];
  logic        s_cyc_o  [2];
  logic        s_stb_o  [2];
  logic        s_we_o   [2];

  int n_checks = 0;
  int n_fail   = 0;

  // Model: own = -1 idle, 0/1 master owning the bus, 2 = error cycle.
  int own   [2] = '{-1, -1};
  int lastm [2] = '{0, 0};
  int stall [2] = '{0, 0};

  wb_bus_arbiter #(.FIXED_PRIO(1), .TIMEOUT(4)) u_fix (
    .clk_i(clk), .rst_i(rst),
    .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_sel_i(m0_sel),
    .m0_addr_i(m0_addr), .m0_dat_i(m0_dat), .m0_dat_o(m0_dat_o[0]),
    .m0_ack_o(m0_ack_o[0]), .m0_err_o(m0_err_o[0]),
    .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_sel_i(m1_sel),
    .m1_addr_i(m1_addr), .m1_dat_i(m1_dat), .m1_dat_o(m1_dat_o[0]),
    .m1_ack_o(m1_ack_o[0]), .m1_err_o(m1_err_o[0]),
    .s_cyc_o(s_cyc_o[0]), .s_stb_o(s_stb_o[0]), .s_we_o(s_we_o[0]),
    .s_sel_o(s_sel_o[0]), .s_addr_o(s_addr_o[0]), .s_dat_o(s_dat_o[0]),
    .s_dat_i(s_dat), .s_ack_i(s_ack), .s_err_i(s_err), .grant_o(grant_o[0])
  );

  wb_bus_arbiter #(.FIXED_PRIO(0), .TIMEOUT(6)) u_rr (
    .clk_i(clk), .rst_i(rst),
    .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_sel_i(m0_sel),
    .m0_addr_i(m0_addr), .m0_dat_i(m0_dat), .m0_dat_o(m0_dat_o[1]),
    .m0_ack_o(m0_ack_o[1]), .m0_err_o(m0_err_o[1]),
    .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_sel_i(m1_sel),
    .m1_addr_i(m1_addr), .m1_dat_i(m1_dat), .m1_dat_o(m1_dat_o[1]),
    .m1_ack_o(m1_ack_o[1]), .m1_err_o(m1_err_o[1]),
    .s_cyc_o(s_cyc_o[1]), .s_stb_o(s_stb_o[1]), .s_we_o(s_we_o[1]),
    .s_sel_o(s_sel_o[1]), .s_addr_o(s_addr_o[1]), .s_dat_o(s_dat_o[1]),
    .s_dat_i(s_dat), .s_ack_i(s_ack), .s_err_i(s_err), .grant_o(grant_o[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int to_of(int k);
    return (k == 0) ? 4 : 6;
  endfunction

  function automatic logic cyc_of(int x);
    return (x == 1) ? m1_cyc : m0_cyc;
  endfunction

  function automatic logic stb_of(int x);
    return (x == 1) ? m1_stb : m0_stb;
  endfunction

  // Expected {grant, s_cyc, s_stb, s_we, m0_ack, m1_ack, m0_err, m1_err}.
  function automatic logic [8:0] exp_ctl(int k);
    logic [8:0] r;
    r = 9'd0;
    if (own[k] == 0)
      r = {2'b01, m0_cyc, m0_stb, m0_we, s_ack, 1'b0, s_err, 1'b0};
    else if (own[k] == 1)
      r = {2'b10, m1_cyc, m1_stb, m1_we, 1'b0, s_ack, 1'b0, s_err};
    else if (own[k] == 2)
      r = {7'd0, (lastm[k] == 0), (lastm[k] == 1)};
    return r;
  endfunction

  // Expected {s_sel, s_addr, s_dat}.
  function automatic logic [67:0] exp_bus(int k);
    logic [67:0] r;
    r = 68'd0;
    if (own[k] == 0)      r = {m0_sel, m0_addr, m0_dat};
    else if (own[k] == 1) r = {m1_sel, m1_addr, m1_dat};
    return r;
  endfunction

  // Advance the model by the rules for the inputs present at this edge.
  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        own[k] = -1; lastm[k] = 0; stall[k] = 0;
      end else if (own[k] == -1) begin
        stall[k] = 0;
        if (m0_cyc && m1_cyc) own[k] = ((k == 0) || (lastm[k] == 0)) ? 1 : 0;
        else if (m1_cyc)      own[k] = 1;
        else if (m0_cyc)      own[k] = 0;
      end else if (own[k] == 2) begin
        own[k] = -1;
      end else begin
        int x = own[k];
        if (!cyc_of(x)) begin
          own[k] = -1; lastm[k] = x;
        end else if (stb_of(x) && !s_ack && !s_err) begin
          if (stall[k] + 1 >= to_of(k)) begin
            own[k] = 2; lastm[k] = x; stall[k] = 0;
          end else begin
            stall[k] = stall[k] + 1;
          end
        end else begin
          stall[k] = 0;
        end
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_masters();
    m0_cyc = 1'b0; m0_stb = 1'b0; m1_cyc = 1'b0; m1_stb = 1'b0;
    s_ack = 1'b0; s_err = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_masters();
    tick();
    tick();
    s_ack = 1'b1;
    s_err = 1'b1;
    s_dat = $urandom;
    #1;
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if ({grant_o[k], s_cyc_o[k], s_stb_o[k], s_we_o[k], m0_ack_o[k], m1_ack_o[k],
           m0_err_o[k], m1_err_o[k]} !== 9'd0) begin
        n_fail++;
        $display("FAIL reset_ctl inst%0d got grant=%b cyc=%b ack=%b%b err=%b%b, required all 0",
                 k, grant_o[k], s_cyc_o[k], m1_ack_o[k], m0_ack_o[k], m1_err_o[k], m0_err_o[k]);
      end
      n_checks++;
      if ({s_sel_o[k], s_addr_o[k], s_dat_o[k]} !== 68'd0) begin
        n_fail++;
        $display("FAIL reset_bus inst%0d got addr=%h, required 0", k, s_addr_o[k]);
      end
      n_checks++;
      if ((m0_dat_o[k] !== s_dat) || (m1_dat_o[k] !== s_dat)) begin
        n_fail++;
        $display("FAIL reset_rdata inst%0d got %h/%h, required %h", k, m0_dat_o[k], m1_dat_o[k], s_dat);
      end
    end
    rst = 1'b0;
    s_ack = 1'b0;
    s_err = 1'b0;
    tick();
  endtask

  task automatic test_single_read();
    int acks0 [2] = '{0, 0};
    int acks1 [2] = '{0, 0};
    m0_cyc = 1'b1; m0_stb = 1'b1; m0_we = 1'b0; m0_sel = 4'hf; m0_addr = 32'h0000_0100;
    #1;
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (s_cyc_o[k] !== 1'b0) begin
        n_fail++;
        $display("FAIL read_latency inst%0d got s_cyc=%b, required 0", k, s_cyc_o[k]);
      end
    end
    tick();
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if ({s_cyc_o[k], grant_o[k], s_addr_o[k]} !== {1'b1, 2'b01, 32'h0000_0100}) begin
        n_fail++;
        $display("FAIL read_grant inst%0d got cyc=%b grant=%b addr=%h, required 1 01 00000100",
                 k, s_cyc_o[k], grant_o[k], s_addr_o[k]);
      end
    end
    for (int c = 0; c < 5; c++) begin
      s_ack = (c == 2);
      if (c == 3) begin m0_cyc = 1'b0; m0_stb = 1'b0; end
      #1;
      for (int k = 0; k < 2; k++) begin
        acks0[k] += int'(m0_ack_o[k]);
        acks1[k] += int'(m1_ack_o[k]);
      end
      tick();
    end
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if ((acks0[k] != 1) || (acks1[k] != 0)) begin
        n_fail++;
        $display("FAIL read_acks inst%0d got m0=%0d m1=%0d pulses, required 1 and 0", k, acks0[k], acks1[k]);
      end
      n_checks++;
      if (grant_o[k] !== 2'b00) begin
        n_fail++;
        $display("FAIL read_release inst%0d got grant=%b, required 00", k, grant_o[k]);
      end
    end
  endtask

  task automatic test_fixed_prio();
    logic [1:0] exp_g;
    m0_cyc = 1'b1; m0_stb = 1'b1; m0_addr = 32'h0000_0a00;
    m1_cyc = 1'b1; m1_stb = 1'b1; m1_addr = 32'h0000_0b00;
    #1;
    tick();
    for (int c = 0; c < 5; c++) begin
      s_ack = (c == 1);
      if (c == 2) begin m1_cyc = 1'b0; m1_stb = 1'b0; end
      #1;
      exp_g = (c <= 2) ? 2'b10 : ((c == 3) ? 2'b00 : 2'b01);
      n_checks++;
      if (grant_o[0] !== exp_g) begin
        n_fail++;
        $display("FAIL fixed_grant cycle%0d got %b, required %b", c, grant_o[0], exp_g);
      end
      n_checks++;
      if ((c <= 2 && s_addr_o[0] !== 32'h0000_0b00) || (c == 4 && s_addr_o[0] !== 32'h0000_0a00)) begin
        n_fail++;
        $display("FAIL fixed_addr cycle%0d got %h", c, s_addr_o[0]);
      end
      n_checks++;
      if (grant_o[1] !== exp_ctl(1)[8:7]) begin
        n_fail++;
        $display("FAIL fixed_rr_grant cycle%0d got %b, required %b", c, grant_o[1], exp_ctl(1)[8:7]);
      end
      tick();
    end
    idle_masters();
    tick();
    tick();
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_g;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      exp_g = (i % 2 == 0) ? 2'b10 : 2'b01;
      m0_cyc = 1'b1; m0_stb = 1'b1; m1_cyc = 1'b1; m1_stb = 1'b1; s_ack = 1'b0;
      tick();
      s_ack = 1'b1;
      #1;
      n_checks++;
      if (grant_o[1] !== exp_g) begin
        n_fail++;
        $display("FAIL rr_grant round%0d got %b, required %b", i, grant_o[1], exp_g);
      end
      tick();
      s_ack = 1'b0;
      if (exp_g == 2'b10) begin m1_cyc = 1'b0; m1_stb = 1'b0; end
      else begin m0_cyc = 1'b0; m0_stb = 1'b0; end
      tick();
    end
    idle_masters();
    tick();
    tick();
  endtask

  task automatic test_watchdog();
    int errs = 0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m1_cyc = 1'b1; m1_stb = 1'b1; m1_we = 1'b1; m1_addr = $urandom; m1_dat = $urandom;
    tick();
    for (int c = 0; c < 6; c++) begin
      if (c == 4) begin m1_cyc = 1'b0; m1_stb = 1'b0; end
      #1;
      errs += int'(m1_err_o[0]);
      n_checks++;
      if ({grant_o[0], m1_err_o[0], m0_err_o[0]} !== {(c < 4) ? 2'b10 : 2'b00, (c == 4), 1'b0}) begin
        n_fail++;
        $display("FAIL wdog_seq cycle%0d got grant=%b err1=%b err0=%b", c, grant_o[0], m1_err_o[0], m0_err_o[0]);
      end
      n_checks++;
      if (c == 4 && (s_cyc_o[0] !== 1'b0 || s_stb_o[0] !== 1'b0)) begin
        n_fail++;
        $display("FAIL wdog_err_cyc got s_cyc=%b s_stb=%b, required 0 0", s_cyc_o[0], s_stb_o[0]);
      end
      n_checks++;
      if (m1_err_o[1] !== 1'b0) begin
        n_fail++;
        $display("FAIL wdog_long_timeout cycle%0d got err=%b, required 0", c, m1_err_o[1]);
      end
      tick();
    end
    n_checks++;
    if (errs != 1) begin
      n_fail++;
      $display("FAIL wdog_pulses got %0d, required 1", errs);
    end
  endtask

  task automatic test_slave_err();
    logic [1:0] exp_g;
    m0_cyc = 1'b1; m0_stb = 1'b1; m0_addr = $urandom;
    tick();
    for (int c = 0; c < 8; c++) begin
      s_err = (c == 2);
      if (c == 6) begin m0_cyc = 1'b0; m0_stb = 1'b0; end
      #1;
      exp_g = (c <= 6) ? 2'b01 : 2'b00;
      for (int k = 0; k < 2; k++) begin
        n_checks++;
        if ({grant_o[k], m0_err_o[k], m1_err_o[k]} !== {exp_g, (c == 2), 1'b0}) begin
          n_fail++;
          $display("FAIL slave_err inst%0d cycle%0d got grant=%b err0=%b err1=%b, required %b %b 0",
                   k, c, grant_o[k], m0_err_o[k], m1_err_o[k], exp_g, (c == 2));
        end
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    m1_cyc = 1'b1; m1_stb = 1'b1;
    tick();
    s_ack = 1'b1;
    tick();
    s_ack = 1'b0; m1_cyc = 1'b0; m1_stb = 1'b0;
    tick();
    tick();
    m1_cyc = 1'b1; m1_stb = 1'b1;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0; m1_cyc = 1'b0; m1_stb = 1'b0; s_ack = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if ({grant_o[k], s_cyc_o[k], s_stb_o[k], m0_ack_o[k], m1_ack_o[k], m0_err_o[k], m1_err_o[k]} !== 8'd0) begin
        n_fail++;
        $display("FAIL mid_reset inst%0d got grant=%b cyc=%b stb=%b ack1=%b, required all 0",
                 k, grant_o[k], s_cyc_o[k], s_stb_o[k], m1_ack_o[k]);
      end
    end
    tick();
    s_ack = 1'b0;
    m0_cyc = 1'b1; m0_stb = 1'b1; m1_cyc = 1'b1; m1_stb = 1'b1;
    tick();
    n_checks++;
    if (grant_o[1] !== 2'b10) begin
      n_fail++;
      $display("FAIL mid_reset_rr got %b, required 10", grant_o[1]);
    end
    idle_masters();
    tick();
    tick();
  endtask

  task automatic test_random();
    for (int n = 0; n < 800; n++) begin
      rst = ($urandom_range(0, 63) == 0);
      if (m0_cyc) begin if ($urandom_range(0, 7) == 0) m0_cyc = 1'b0; end
      else if ($urandom_range(0, 2) == 0) m0_cyc = 1'b1;
      if (m1_cyc) begin if ($urandom_range(0, 7) == 0) m1_cyc = 1'b0; end
      else if ($urandom_range(0, 2) == 0) m1_cyc = 1'b1;
      m0_stb = m0_cyc & ($urandom_range(0, 3) != 0);
      m1_stb = m1_cyc & ($urandom_range(0, 3) != 0);
      m0_we = $urandom_range(0, 1) == 1; m1_we = $urandom_range(0, 1) == 1;
      m0_sel = 4'($urandom); m1_sel = 4'($urandom);
      m0_addr = $urandom; m1_addr = $urandom; m0_dat = $urandom; m1_dat = $urandom;
      s_ack = ($urandom_range(0, 3) == 0);
      s_err = ($urandom_range(0, 15) == 0);
      s_dat = $urandom;
      #1;
      for (int k = 0; k < 2; k++) begin
        n_checks++;
        if ({grant_o[k], s_cyc_o[k], s_stb_o[k], s_we_o[k], m0_ack_o[k], m1_ack_o[k],
             m0_err_o[k], m1_err_o[k]} !== exp_ctl(k)) begin
          n_fail++;
          $display("FAIL rand_ctl inst%0d step%0d got %b, required %b", k, n,
                   {grant_o[k], s_cyc_o[k], s_stb_o[k], s_we_o[k], m0_ack_o[k], m1_ack_o[k],
                    m0_err_o[k], m1_err_o[k]}, exp_ctl(k));
        end
        n_checks++;
        if ({s_sel_o[k], s_addr_o[k], s_dat_o[k]} !== exp_bus(k)) begin
          n_fail++;
          $display("FAIL rand_bus inst%0d step%0d got %h, required %h", k, n,
                   {s_sel_o[k], s_addr_o[k], s_dat_o[k]}, exp_bus(k));
        end
        n_checks++;
        if ({m0_dat_o[k], m1_dat_o[k]} !== {s_dat, s_dat}) begin
          n_fail++;
          $display("FAIL rand_rdata inst%0d step%0d got %h/%h, required %h", k, n,
                   m0_dat_o[k], m1_dat_o[k], s_dat);
        end
      end
      tick();
    end
    rst = 1'b0;
    idle_masters();
    tick();
  endtask

  initial begin
    rst = 1'b1;
    m0_we = 1'b0; m0_sel = 4'h0; m0_addr = 32'h0; m0_dat = 32'h0;
    m1_we = 1'b0; m1_sel = 4'h0; m1_addr = 32'h0; m1_dat = 32'h0;
    s_dat = 32'h0;
    idle_masters();
    test_reset();
    test_single_read();
    test_fixed_prio();
    test_round_robin();
    test_watchdog();
    test_slave_err();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
